// File: rtl/design1_bist_ctrl_pkg.sv
// Shared types and constants for the BIST controller: FSM encoding, LFSR/MISR
// polynomials, CUT pin ordering and the all-zero seed substitute.
package design1_bist_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int LFSR_W = 14;
    localparam int MISR_W = 8;

    // Tap masks: a set bit k means polynomial tap k+1 feeds the XOR.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 14'h2015;  // taps 14,5,3,1
    localparam logic [MISR_W-1:0] MISR_TAPS = 8'hB8;     // taps 8,6,5,4

    // CUT net names behind each pi/po bit, index 0 first.
    localparam int PI_NODE [LFSR_W] = '{2, 4, 12, 18, 22, 34, 35, 51, 57, 67, 72, 75, 78, 80};
    localparam int PO_NODE [MISR_W] = '{6, 9, 42, 48, 56, 65, 68, 77};

    // An all-zero seed would lock the LFSR; this value replaces it.
    localparam logic [LFSR_W-1:0] SEED_SUBST = 14'h0001;

    function automatic logic [MISR_W-1:0] misr_next(
        input logic [MISR_W-1:0] misr,
        input logic [MISR_W-1:0] resp
    );
        return {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ resp;
    endfunction

endpackage

// File: rtl/design1_bist_ctrl_lfsr.sv
// Fibonacci LFSR pattern generator with synchronous load and advance enable;
// load wins over enable.
module bist_lfsr #(
    parameter int               WIDTH = 14,
    parameter logic [WIDTH-1:0] TAPS  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic [WIDTH-1:0] state
);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= '0;
        end else if (load) begin
            state <= load_value;
        end else if (enable) begin
            state <= {state[WIDTH-2:0], ^(state & TAPS)};
        end
    end

endmodule

// File: rtl/design1_bist_ctrl.sv
// BIST controller: drives LFSR patterns into an external CUT for N cycles,
// compacts the responses in an inline MISR and compares against golden_sig.
module design1_bist_ctrl
    import design1_bist_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LFSR_W-1:0] seed,
    input  logic [CNT_W-1:0]  num_patterns,
    input  logic [MISR_W-1:0] golden_sig,
    output logic [LFSR_W-1:0] pi,
    input  logic [MISR_W-1:0] po,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr;
    logic                lfsr_load, lfsr_en;
    logic [CNT_W-1:0]    cnt_q;
    logic [MISR_W-1:0]   misr_q, po_q, golden_q;
    logic                po_vld_q;
    logic                idle_like, zero_run;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign zero_run  = idle_like && start && (num_patterns == '0);

    bist_lfsr #(
        .WIDTH (LFSR_W),
        .TAPS  (LFSR_TAPS)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .load       (lfsr_load),
        .load_value ((seed == '0) ? SEED_SUBST : seed),
        .enable     (lfsr_en),
        .state      (lfsr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: defaults first so no path through the case leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        lfsr_load = 1'b0;
        lfsr_en   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) state_d = (num_patterns == '0) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    lfsr_load = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    lfsr_en = 1'b1;
                    if (cnt_q == CNT_W'(1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = abort ? ST_IDLE : ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The response captured in RUN cycle k is folded on the following edge,
    // so the DRAIN cycle exists only to fold the final one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            misr_q   <= '0;
            po_q     <= '0;
            po_vld_q <= 1'b0;
            golden_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (zero_run) begin
                        misr_q   <= '0;
                        golden_q <= golden_sig;
                    end
                end
                ST_LOAD: begin
                    if (!abort) begin
                        misr_q   <= '0;
                        cnt_q    <= num_patterns;
                        po_vld_q <= 1'b0;
                        golden_q <= golden_sig;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        po_vld_q <= 1'b0;
                    end else begin
                        po_q     <= po;
                        po_vld_q <= 1'b1;
                        cnt_q    <= cnt_q - CNT_W'(1);
                        if (po_vld_q) misr_q <= misr_next(misr_q, po_q);
                    end
                end
                ST_DRAIN: begin
                    if (!abort && po_vld_q) misr_q <= misr_next(misr_q, po_q);
                    po_vld_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign pi        = (state_q == ST_RUN) ? lfsr : '0;
    assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (misr_q == golden_q);
    assign signature = misr_q;

endmodule

// File: tb/tb_design1_bist_ctrl.sv
// Self-checking bench for design1_bist_ctrl: a table of complete BIST runs
// plus directed sequences for pattern order, abort, async reset and start-while-busy.
module tb_design1_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [13:0] seed;
    logic [15:0] num_patterns;
    logic [7:0]  golden_sig;
    logic [13:0] pi;
    logic [7:0]  po;
    logic        busy, done, pass;
    logic [7:0]  signature;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Stand-in CUT: purely combinational from pi.
    assign po = pi[7:0] ^ pi[13:6];

    design1_bist_ctrl #(.CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .seed         (seed),
        .num_patterns (num_patterns),
        .golden_sig   (golden_sig),
        .pi           (pi),
        .po           (po),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature)
    );

    typedef struct {
        logic [13:0] seed;
        int          n;
        logic [7:0]  golden;
        logic [7:0]  exp_sig;
        logic        exp_pass;
        int          exp_lat;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [13:0] m_lfsr(input logic [13:0] s);
        return {s[12:0], s[13] ^ s[4] ^ s[2] ^ s[0]};
    endfunction

    function automatic logic [7:0] m_misr(input logic [7:0] m, input logic [7:0] r);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ r;
    endfunction

    function automatic logic [7:0] m_cut(input logic [13:0] p);
        return p[7:0] ^ p[13:6];
    endfunction

    function automatic logic [7:0] m_sig(input logic [13:0] sd, input int n);
        logic [13:0] s;
        logic [7:0]  m;
        s = (sd == 14'h0) ? 14'h0001 : sd;
        m = 8'h00;
        for (int i = 0; i < n; i++) begin
            m = m_misr(m, m_cut(s));
            s = m_lfsr(s);
        end
        return m;
    endfunction

    // Launch one run and count edges after the start-sampling edge until done
    // is seen; start is re-pulsed once at edge count poke_at (negative = never).
    task automatic run_vector(input logic [13:0] sd, input int n, input logic [7:0] g,
                              input int poke_at, output int lat);
        int budget;
        budget = n + 10;
        @(negedge clk);
        seed         = sd;
        num_patterns = n[15:0];
        golden_sig   = g;
        start        = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < budget) begin
            if (lat == poke_at) start = 1'b1;
            @(posedge clk);
            #1 start = 1'b0;
            lat++;
        end
    endtask

    initial begin
        int lat;
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        seed         = '0;
        num_patterns = '0;
        golden_sig   = '0;

        // Rows 0-4 are worked by hand (CUT gives po = 01,03,07,0E for seed 1);
        // larger runs take their signature from the reference fold.
        vecs[0] = '{14'h0001, 4, 8'h04, 8'h04, 1'b1, 6};
        vecs[1] = '{14'h0000, 1, 8'h01, 8'h01, 1'b1, 3};
        vecs[2] = '{14'h0000, 1, 8'h02, 8'h01, 1'b0, 3};
        vecs[3] = '{14'h0001, 0, 8'h00, 8'h00, 1'b1, 0};
        vecs[4] = '{14'h0001, 0, 8'h5A, 8'h00, 1'b0, 0};
        vecs[5] = '{14'h1234, 20, m_sig(14'h1234, 20), m_sig(14'h1234, 20), 1'b1, 22};
        vecs[6] = '{14'h3FFF, 100, m_sig(14'h3FFF, 100) ^ 8'h80, m_sig(14'h3FFF, 100), 1'b0, 102};
        vecs[7] = '{14'h2A5B, 17, m_sig(14'h2A5B, 17), m_sig(14'h2A5B, 17), 1'b1, 19};
        vecs[8] = '{14'h0ACE, 65535, m_sig(14'h0ACE, 65535), m_sig(14'h0ACE, 65535), 1'b1, 65537};

        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_sig",  signature, 0);
        check("rst_pi",   pi, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Pattern order for seed 1, N=4, one edge at a time.
        @(negedge clk);
        seed = 14'h0001; num_patterns = 16'd4; golden_sig = 8'h04; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("seq_load_pi",   pi, 0);
        check("seq_load_busy", busy, 1);
        begin
            logic [13:0] exp_pi [4];
            exp_pi = '{14'h0001, 14'h0003, 14'h0007, 14'h000E};
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1 check($sformatf("seq_run_pi%0d", k), pi, exp_pi[k]);
            end
        end
        @(posedge clk);
        #1;
        check("seq_drain_pi",   pi, 0);
        check("seq_drain_busy", busy, 1);
        check("seq_drain_done", done, 0);
        @(posedge clk);
        #1;
        check("seq_done",      done, 1);
        check("seq_done_busy", busy, 0);
        check("seq_sig",       signature, 8'h04);
        check("seq_pass",      pass, 1);

        for (int i = 0; i < NV; i++) begin
            run_vector(vecs[i].seed, vecs[i].n, vecs[i].golden, -1, lat);
            check($sformatf("v%0d_lat", i),  lat, vecs[i].exp_lat);
            check($sformatf("v%0d_done", i), done, 1);
            check($sformatf("v%0d_busy", i), busy, 0);
            check($sformatf("v%0d_sig", i),  signature, vecs[i].exp_sig);
            check($sformatf("v%0d_pass", i), pass, vecs[i].exp_pass);
        end

        // Abort in RUN cycle 3 of N=10: only po(0001)=01 has been folded.
        @(negedge clk);
        seed = 14'h0001; num_patterns = 16'd10; golden_sig = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_pi",   pi, 0);
        check("abort_sig",  signature, 8'h01);
        repeat (3) @(posedge clk);
        #1 check("abort_stay_idle", done, 0);
        run_vector(14'h0001, 4, 8'h04, -1, lat);
        check("post_abort_lat",  lat, 6);
        check("post_abort_sig",  signature, 8'h04);
        check("post_abort_pass", pass, 1);

        // Asynchronous reset landing between clock edges mid-RUN.
        @(negedge clk);
        seed = 14'h0155; num_patterns = 16'd50; golden_sig = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_pi",   pi, 0);
        check("arst_sig",  signature, 0);
        check("arst_done", done, 0);
        check("arst_pass", pass, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1 check("arst_no_done", done, 0);

        // A start pulse mid-run must not restart or stretch the run.
        run_vector(14'h0777, 6, m_sig(14'h0777, 6), 3, lat);
        check("busy_start_lat",  lat, 8);
        check("busy_start_sig",  signature, m_sig(14'h0777, 6));
        check("busy_start_pass", pass, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
